// File: rtl/alu_sequential.sv
// Handshaked sequential ALU: single-cycle arithmetic/logic ops plus an
// iterative left shift and an iterative shift-add multiply. Result and flags
// are registered and presented with valid/ready until the consumer takes them.
module alu_sequential #(
  parameter int WIDTH = 32
) (
  input  logic             clock,
  input  logic             reset_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [2:0]       control,
  input  logic [WIDTH-1:0] input_a,
  input  logic [WIDTH-1:0] input_b,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] result,
  output logic             overflow,
  output logic             carry,
  output logic             negative,
  output logic             zero
);

  localparam int SHAMT_WIDTH = $clog2(WIDTH);
  localparam int CNT_WIDTH   = SHAMT_WIDTH + 1;

  typedef enum logic [1:0] {IDLE, BUSY, DONE} state_t;
  typedef enum logic [2:0] {
    OP_ADD = 3'b000, OP_SUB = 3'b001, OP_AND = 3'b010, OP_OR  = 3'b011,
    OP_XOR = 3'b100, OP_SLT = 3'b101, OP_SHL = 3'b110, OP_MUL = 3'b111
  } op_t;

  state_t                 state, state_next;
  op_t                    op_q;
  logic [WIDTH-1:0]       opnd_q;   // shifting operand (SHL) or multiplicand (MUL)
  logic [2*WIDTH-1:0]     acc_q;    // {partial product, remaining multiplier}
  logic [CNT_WIDTH-1:0]   count_q;  // iterations left in BUSY

  logic [SHAMT_WIDTH-1:0] shamt;
  logic                   multi_cycle;
  logic [WIDTH:0]         add_sum, sub_sum;
  logic [WIDTH-1:0]       quick_result;
  logic                   quick_carry, quick_overflow;
  logic [WIDTH-1:0]       shl_next;
  logic [WIDTH:0]         mul_sum;
  logic [2*WIDTH-1:0]     mul_next;
  logic                   last_step;
  logic                   load_en;
  logic [WIDTH-1:0]       load_result;
  logic                   load_carry, load_overflow;

  assign shamt       = input_b[SHAMT_WIDTH-1:0];
  assign multi_cycle = (control == OP_MUL) || ((control == OP_SHL) && (shamt != '0));

  // State register.
  always_ff @(posedge clock or negedge reset_n) begin
    // NOTE: sequential state uses non-blocking assignments so every register
    // samples the pre-edge values regardless of block ordering.
    if (!reset_n) state <= IDLE;
    else          state <= state_next;
  end

  // Next-state and handshake outputs.
  always_comb begin
    // NOTE: every output of this block gets a default first so no path can
    // leave a value unassigned and infer a latch.
    state_next = state;
    in_ready   = 1'b0;
    out_valid  = 1'b0;
    case (state)
      IDLE: begin
        in_ready = 1'b1;
        if (in_valid) state_next = multi_cycle ? BUSY : DONE;
      end
      BUSY: begin
        if (last_step) state_next = DONE;
      end
      DONE: begin
        out_valid = 1'b1;
        if (out_ready) state_next = IDLE;
      end
      default: state_next = IDLE;
    endcase
  end

  // Single-cycle results, one iteration step of SHL/MUL, and result load select.
  always_comb begin
    add_sum        = {1'b0, input_a} + {1'b0, input_b};
    sub_sum        = {1'b0, input_a} + {1'b0, ~input_b} + {{WIDTH{1'b0}}, 1'b1};
    quick_result   = '0;
    quick_carry    = 1'b0;
    quick_overflow = 1'b0;
    case (op_t'(control))
      OP_ADD: begin
        quick_result   = add_sum[WIDTH-1:0];
        quick_carry    = add_sum[WIDTH];
        quick_overflow = (input_a[WIDTH-1] == input_b[WIDTH-1]) &&
                         (add_sum[WIDTH-1] != input_a[WIDTH-1]);
      end
      OP_SUB: begin
        quick_result   = sub_sum[WIDTH-1:0];
        quick_carry    = sub_sum[WIDTH];
        quick_overflow = (input_a[WIDTH-1] != input_b[WIDTH-1]) &&
                         (sub_sum[WIDTH-1] != input_a[WIDTH-1]);
      end
      OP_AND: quick_result = input_a & input_b;
      OP_OR:  quick_result = input_a | input_b;
      OP_XOR: quick_result = input_a ^ input_b;
      OP_SLT: quick_result = {{(WIDTH-1){1'b0}}, ($signed(input_a) < $signed(input_b))};
      OP_SHL: quick_result = input_a;  // only reaches here with amount 0
      OP_MUL: quick_result = '0;       // always multi-cycle
      default: quick_result = '0;
    endcase

    shl_next  = {opnd_q[WIDTH-2:0], 1'b0};
    mul_sum   = {1'b0, acc_q[2*WIDTH-1:WIDTH]} + (acc_q[0] ? {1'b0, opnd_q} : {(WIDTH+1){1'b0}});
    mul_next  = {mul_sum, acc_q[WIDTH-1:1]};
    last_step = (count_q == CNT_WIDTH'(1));

    load_en       = 1'b0;
    load_result   = quick_result;
    load_carry    = quick_carry;
    load_overflow = quick_overflow;
    if ((state == IDLE) && in_valid && !multi_cycle) begin
      load_en = 1'b1;
    end else if ((state == BUSY) && last_step) begin
      load_en       = 1'b1;
      load_overflow = 1'b0;
      if (op_q == OP_SHL) begin
        load_result = shl_next;
        load_carry  = opnd_q[WIDTH-1];
      end else begin
        load_result = mul_next[WIDTH-1:0];
        load_carry  = |mul_next[2*WIDTH-1:WIDTH];
      end
    end
  end

  // Operand capture on accept and per-cycle iteration while BUSY.
  always_ff @(posedge clock or negedge reset_n) begin
    // NOTE: the working registers are reset as well so an abandoned operation
    // leaves no residue and the post-reset state is fully defined.
    if (!reset_n) begin
      op_q    <= OP_ADD;
      opnd_q  <= '0;
      acc_q   <= '0;
      count_q <= '0;
    end else if ((state == IDLE) && in_valid) begin
      op_q    <= op_t'(control);
      opnd_q  <= input_a;
      acc_q   <= {{WIDTH{1'b0}}, input_b};
      count_q <= (control == OP_MUL) ? CNT_WIDTH'(WIDTH) : CNT_WIDTH'(shamt);
    end else if (state == BUSY) begin
      count_q <= count_q - CNT_WIDTH'(1);
      if (op_q == OP_SHL) opnd_q <= shl_next;
      else                acc_q  <= mul_next;
    end
  end

  // Output registers update only when an operation completes.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      result   <= '0;
      carry    <= 1'b0;
      overflow <= 1'b0;
      negative <= 1'b0;
      zero     <= 1'b0;
    end else if (load_en) begin
      result   <= load_result;
      carry    <= load_carry;
      overflow <= load_overflow;
      negative <= load_result[WIDTH-1];
      zero     <= (load_result == '0);
    end
  end

endmodule

// File: tb/tb_alu_sequential.sv
// Scoreboard bench for alu_sequential: a driver issues operations and pushes
// the reference-model response; a monitor pops and compares on out_valid.
module tb_alu_sequential;

  localparam int W  = 32;
  localparam int W8 = 8;

  logic          clock = 1'b0;
  logic          reset_n = 1'b0;
  logic          in_valid, in_ready, out_valid, out_ready;
  logic [2:0]    control;
  logic [W-1:0]  input_a, input_b, result;
  logic          overflow, carry, negative, zero;

  logic          in_valid8, in_ready8, out_valid8;
  logic          out_ready8 = 1'b1;
  logic [2:0]    control8;
  logic [W8-1:0] input_a8, input_b8, result8;
  logic          overflow8, carry8, negative8, zero8;

  alu_sequential #(.WIDTH(W)) dut (
    .clock(clock), .reset_n(reset_n), .in_valid(in_valid), .in_ready(in_ready),
    .control(control), .input_a(input_a), .input_b(input_b),
    .out_valid(out_valid), .out_ready(out_ready), .result(result),
    .overflow(overflow), .carry(carry), .negative(negative), .zero(zero)
  );

  alu_sequential #(.WIDTH(W8)) dut8 (
    .clock(clock), .reset_n(reset_n), .in_valid(in_valid8), .in_ready(in_ready8),
    .control(control8), .input_a(input_a8), .input_b(input_b8),
    .out_valid(out_valid8), .out_ready(out_ready8), .result(result8),
    .overflow(overflow8), .carry(carry8), .negative(negative8), .zero(zero8)
  );

  always #5 clock = ~clock;

  int cyc = 0;
  always @(posedge clock) cyc <= cyc + 1;

  typedef struct {
    logic [W-1:0] res;
    logic         c, v, n, z;
    int           lat;
    int           acc_cyc;
  } exp_t;

  exp_t sb[$];
  exp_t cur;
  int   checks = 0;
  int   errors = 0;
  bit   seen = 1'b0;
  bit   hs_pending = 1'b0;
  bit   hold_low = 1'b0;

  task automatic check(input string name, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%0h expected=%0h (cycle %0d)", name, got, exp, cyc);
    end
  endtask

  // Reference model: computed from the arithmetic definition of each opcode.
  function automatic exp_t model(input logic [2:0] op, input logic [W-1:0] a, input logic [W-1:0] b);
    exp_t e;
    longint sa, sb_s, s;
    logic [63:0] p;
    int n;
    sa   = $signed(a);
    sb_s = $signed(b);
    e.c = 1'b0; e.v = 1'b0; e.lat = 1; e.acc_cyc = 0; e.res = '0;
    case (op)
      3'd0: begin
        p = {32'b0, a} + {32'b0, b};
        e.res = p[W-1:0];
        e.c = (p > 64'hFFFF_FFFF);
        s = sa + sb_s;
        e.v = (s > 64'sd2147483647) || (s < -64'sd2147483648);
      end
      3'd1: begin
        e.res = a - b;
        e.c = (a >= b);
        s = sa - sb_s;
        e.v = (s > 64'sd2147483647) || (s < -64'sd2147483648);
      end
      3'd2: e.res = a & b;
      3'd3: e.res = a | b;
      3'd4: e.res = a ^ b;
      3'd5: e.res = (sa < sb_s) ? 1 : 0;
      3'd6: begin
        n = int'(b[4:0]);
        e.res = a << n;
        e.c = (n > 0) ? a[W-n] : 1'b0;
        e.lat = (n > 0) ? n + 1 : 1;
      end
      default: begin
        p = {32'b0, a} * {32'b0, b};
        e.res = p[W-1:0];
        e.c = (p[63:32] != 0);
        e.lat = W + 1;
      end
    endcase
    e.n = e.res[W-1];
    e.z = (e.res == 0);
    return e;
  endfunction

  // Random backpressure on the result side, forced low during the hold test.
  always @(negedge clock) out_ready = hold_low ? 1'b0 : ($urandom_range(3) != 0);

  // Monitor: compares each presented result against the scoreboard head.
  always begin
    @(negedge clock);
    #1;
    if (!reset_n) begin
      seen = 1'b0;
      hs_pending = 1'b0;
    end else begin
      if (hs_pending) begin
        check("in_ready_after_handshake", in_ready, 1);
        hs_pending = 1'b0;
      end
      if (out_valid) begin
        if (!seen) begin
          seen = 1'b1;
          if (sb.size() == 0) begin
            check("unexpected_output", 1, 0);
            cur.res = result; cur.c = carry; cur.v = overflow; cur.n = negative; cur.z = zero;
          end else begin
            cur = sb.pop_front();
            check("result", result, cur.res);
            check("carry", carry, cur.c);
            check("overflow", overflow, cur.v);
            check("negative", negative, cur.n);
            check("zero", zero, cur.z);
            check("latency", cyc - cur.acc_cyc, cur.lat);
          end
        end else begin
          check("hold_result", result, cur.res);
          check("hold_flags", {carry, overflow, negative, zero}, {cur.c, cur.v, cur.n, cur.z});
        end
        check("in_ready_in_done", in_ready, 0);
        if (out_ready) hs_pending = 1'b1;
      end else begin
        seen = 1'b0;
      end
    end
  end

  task automatic issue(input logic [2:0] op, input logic [W-1:0] a, input logic [W-1:0] b);
    exp_t e;
    int g = 0;
    @(negedge clock);
    while (!in_ready && g < 500) begin
      @(negedge clock);
      g++;
    end
    if (g >= 500) begin
      check("issue_wait_in_ready", in_ready, 1);
      return;
    end
    control  = op;
    input_a  = a;
    input_b  = b;
    in_valid = 1'b1;
    e = model(op, a, b);
    e.acc_cyc = cyc;
    sb.push_back(e);
    @(negedge clock);
    in_valid = 1'b0;
    control  = 3'($urandom);
    input_a  = $urandom;
    input_b  = $urandom;
  endtask

  task automatic drain();
    int g = 0;
    while ((sb.size() != 0 || out_valid) && g < 2000) begin
      @(negedge clock);
      g++;
    end
    check("drain_completed", g < 2000, 1);
  endtask

  task automatic mul8(input logic [W8-1:0] a, input logic [W8-1:0] b);
    int start;
    int g = 0;
    logic [15:0] p;
    @(negedge clock);
    check("w8_in_ready", in_ready8, 1);
    control8  = 3'b111;
    input_a8  = a;
    input_b8  = b;
    in_valid8 = 1'b1;
    start = cyc;
    @(negedge clock);
    in_valid8 = 1'b0;
    while (!out_valid8 && g < 50) begin
      @(negedge clock);
      g++;
    end
    p = 16'(a) * 16'(b);
    check("w8_latency", cyc - start, W8 + 1);
    check("w8_result", result8, p[7:0]);
    check("w8_carry", carry8, p[15:8] != 0);
    check("w8_flags", {overflow8, negative8, zero8}, {1'b0, p[7], p[7:0] == 0});
    @(negedge clock);
  endtask

  logic [2:0]   d_op [16] = '{3'd0, 3'd0, 3'd0, 3'd1, 3'd1, 3'd1, 3'd1, 3'd2,
                              3'd3, 3'd4, 3'd5, 3'd5, 3'd6, 3'd6, 3'd6, 3'd7};
  logic [W-1:0] d_a  [16] = '{32'd10, 32'hFFFF_FFFF, 32'h7FFF_FFFF, 32'd10, 32'd1, 32'd1,
                              32'h8000_0000, 32'd3, 32'd3, 32'd3, 32'hFFFF_FFFB, 32'd3,
                              32'h8000_0001, 32'h8000_0001, 32'h1234, 32'h1_0000};
  logic [W-1:0] d_b  [16] = '{32'd7, 32'd1, 32'd1, 32'd7, 32'd2, 32'd1, 32'd1, 32'd5,
                              32'd5, 32'd5, 32'd3, 32'hFFFF_FFFB, 32'd4, 32'd1, 32'd0, 32'h1_0000};

  initial begin
    #1_000_000;
    $display("FAIL global_timeout");
    $fatal(1, "simulation time limit exceeded");
  end

  initial begin
    logic [2:0]   op;
    logic [W-1:0] a, b;
    in_valid = 1'b0; control = '0; input_a = '0; input_b = '0;
    in_valid8 = 1'b0; control8 = '0; input_a8 = '0; input_b8 = '0;
    reset_n = 1'b0;
    repeat (3) @(negedge clock);
    #2;
    check("reset_in_ready", in_ready, 1);
    check("reset_out_valid", out_valid, 0);
    check("reset_result", result, 0);
    check("reset_flags", {carry, overflow, negative, zero}, 0);
    @(negedge clock);
    reset_n = 1'b1;

    for (int i = 0; i < 16; i++) issue(d_op[i], d_a[i], d_b[i]);
    drain();

    // Consumer stalls in DONE; the monitor checks the held values each cycle.
    hold_low = 1'b1;
    issue(3'd0, 32'd10, 32'd7);
    for (int g = 0; g < 50 && !out_valid; g++) @(negedge clock);
    repeat (6) @(negedge clock);
    hold_low = 1'b0;
    drain();

    // Requests raised during BUSY must not be accepted.
    issue(3'd7, 32'd3, 32'd5);
    repeat (3) begin
      @(negedge clock);
      in_valid = 1'b1;
      control  = 3'd0;
      input_a  = $urandom;
      input_b  = $urandom;
    end
    @(negedge clock);
    in_valid = 1'b0;
    drain();

    for (int i = 0; i < 60; i++) begin
      op = 3'($urandom_range(7));
      a  = $urandom;
      b  = $urandom;
      if ($urandom_range(5) == 0) b = a;
      if ($urandom_range(5) == 1) a = 32'h8000_0000;
      issue(op, a, b);
    end
    drain();

    // Reset ten cycles into a multiply: abandoned, outputs clear at once.
    issue(3'd7, 32'h1_0000, 32'h1_0000);
    repeat (9) @(negedge clock);
    reset_n = 1'b0;
    sb.delete();
    #2;
    check("midop_reset_in_ready", in_ready, 1);
    check("midop_reset_out_valid", out_valid, 0);
    check("midop_reset_result", result, 0);
    check("midop_reset_flags", {carry, overflow, negative, zero}, 0);
    @(negedge clock);
    reset_n = 1'b1;
    issue(3'd0, 32'd10, 32'd7);
    drain();

    mul8(8'd15, 8'd17);
    for (int i = 0; i < 4; i++) mul8(8'($urandom), 8'($urandom));

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/alu_sequential.md
Name: alu_sequential

Overview:
- Parametrised, handshaked successor to the 32-bit combinational ALU.
- Generalised to WIDTH bits with a 3-bit opcode.
- Adds two multi-cycle operations: an iterative left shift and an iterative shift-add multiply.
- Result and the four flags are held in output registers. The block sits between the datapath issue stage and writeback, using valid/ready on both sides.

Parameters:
- WIDTH, 32, operand/result width; power of two, at least 4.
- SHAMT_WIDTH, $clog2(WIDTH), derived localparam; shift amount taken from input_b[SHAMT_WIDTH-1:0].

Ports:
- clock  input  1  rising-edge clock
- reset_n  input  1  asynchronous, active-low reset
- in_valid  input  1  operation request
- in_ready  output  1  block can accept a request
- control  input  3  opcode
- input_a  input  WIDTH  operand A
- input_b  input  WIDTH  operand B (shift amount for SHL)
- out_valid  output  1  result/flags valid
- out_ready  input  1  consumer accepts result
- result  output  WIDTH  registered result
- overflow  output  1  signed overflow
- carry  output  1  carry / no-borrow / shifted-out bit / product overflow
- negative  output  1  result[WIDTH-1]
- zero  output  1  result == 0

Behaviour:
- Clock and reset: one clock, `clock`. `reset_n` is asynchronous and active-low.
- Reset state: IDLE. in_ready=1, out_valid=0, result=0, all flags=0, internal counter/accumulators=0.
- Reset asserted mid-operation: the operation is abandoned with no output, and the block returns to the reset state immediately.
- Opcodes:
  - 000 ADD
  - 001 SUB
  - 010 AND
  - 011 OR
  - 100 XOR
  - 101 SLT (signed; result 1 or 0)
  - 110 SHL (logical left by input_b[SHAMT_WIDTH-1:0])
  - 111 MUL (unsigned, low WIDTH bits of product)
- State machine: IDLE -> (BUSY) -> DONE -> IDLE.
  - IDLE: in_ready=1. Accept when in_valid & in_ready. control, input_a and input_b are captured on the accept edge; later input changes are ignored until the next accept.
  - Single-cycle ops (000-101), and SHL with amount 0: IDLE -> DONE. out_valid rises the cycle after accept (latency 1).
  - SHL with amount n>0: IDLE -> BUSY. Shift one bit per cycle for n cycles, then DONE. out_valid appears n+1 cycles after accept.
  - MUL: IDLE -> BUSY for exactly WIDTH cycles of shift-add over a 2*WIDTH accumulator, then DONE. out_valid appears WIDTH+1 cycles after accept.
  - BUSY: in_ready=0, out_valid=0.
  - DONE: out_valid=1, in_ready=0. result and flags are stable until out_valid & out_ready, then IDLE on the next edge.
  - out_ready is ignored outside DONE.
  - Maximum throughput is one op per 2 cycles. No back-to-back accept in the handshake cycle.
- Flag rules (all registered with result):
  - negative = result[WIDTH-1] and zero = (result==0), for every op.
  - ADD: carry = carry-out of bit WIDTH-1; overflow = operands same sign and result sign differs.
  - SUB: A + ~B + 1. carry = 1 when A >= B unsigned (no borrow); overflow = operands differ in sign and result sign differs from A.
  - AND/OR/XOR/SLT: carry=0, overflow=0.
  - SHL: carry = last bit shifted out of bit WIDTH-1 (0 when amount 0); overflow=0.
  - MUL: carry = 1 if upper WIDTH bits of the full product are nonzero; overflow=0.
- Arithmetic wraps modulo 2^WIDTH. No exceptions or stalls beyond those above.
- result and flags hold their last value in IDLE and BUSY; they update only on the transition into DONE.

Test Plan:
- ADD, WIDTH=32:
  - 10+7: out_valid 1 cycle after accept, result=17, C=V=N=Z=0.
  - 0xFFFFFFFF+1: result=0, carry=1, zero=1, overflow=0.
  - 0x7FFFFFFF+1: result=0x80000000, overflow=1, negative=1, carry=0.
- SUB:
  - 10-7: result=3, carry=1.
  - 1-2: result=0xFFFFFFFF, carry=0, negative=1.
  - 1-1: result=0, zero=1, carry=1.
  - 0x80000000-1: overflow=1.
- Logic/SLT: AND 0b0011,0b0101 -> 0b0001. OR -> 0b0111. XOR -> 0b0110. SLT -5,3 -> 1. SLT 3,-5 -> 0.
- Multi-cycle:
  - SHL 0x80000001 by 4: out_valid exactly 5 cycles after accept, result=0x00000010, carry=0.
  - SHL 0x80000001 by 1: result=0x00000002, carry=1.
  - MUL 0x10000*0x10000: out_valid 33 cycles after accept, result=0, carry=1, zero=1.
  - WIDTH=8 instance, MUL 15*17: result=255, carry=0, latency 9.
- Handshake:
  - out_ready held low 5 cycles in DONE: result/flags stable, in_ready=0.
  - in_valid pulsed during BUSY with different operands: ignored, result matches the first op.
  - After out handshake, in_ready=1 the next cycle.
- Reset: assert reset_n=0 mid-MUL (cycle 10): outputs zero immediately, in_ready=1. A new ADD issued after release completes correctly with latency 1.
